// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state type and default widths for the RAM address arbiter.
package ram_arb_pkg;
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
    localparam int BEAT_W        = 8;
    localparam int DEF_N_CH      = 4;
    localparam int DEF_AW        = 16;
    localparam int DEF_MAX_BURST = 16;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: one-hot winner among requests; round-robin from Ptr when RAM_ARB_RR_EN is defined, else lowest index.
module ram_arb_pick #(
    parameter int N_CH = 4,
    parameter int PW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] Req,
`ifdef RAM_ARB_RR_EN
    input  logic [PW-1:0]   Ptr,
`endif
    output logic [N_CH-1:0] Winner
);
`ifdef RAM_ARB_RR_EN
    logic [N_CH-1:0] rot, rot_win;
    // rotate so Ptr sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        rot     = N_CH'({Req, Req} >> Ptr);
        rot_win = rot & -rot;
        Winner  = N_CH'(({rot_win, rot_win} << Ptr) >> N_CH);
    end
`else
    always_comb Winner = Req & -Req;
`endif
endmodule

// File: rtl/ram_addr_arbiter.sv
// ram_addr_arbiter: N-channel request/grant arbiter with bursts onto one RAM address port.
// RAM_ARB_RR_EN selects round-robin arbitration; fixed priority (channel 0 highest) otherwise.
module ram_addr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int AW        = DEF_AW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N_CH-1:0]      Req,
    input  logic [N_CH-1:0]      Last,
    input  logic [N_CH*AW-1:0]   AddrIn,
    input  logic                 RamReady,
    output logic [N_CH-1:0]      Grant,
    output logic [N_CH-1:0]      Take,
    output logic [AW-1:0]        AddressToRAM,
    output logic                 AddrValid,
    output logic [BEAT_W-1:0]    BeatCount
);
    localparam int PW = $clog2(N_CH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    state_t              state_q;
    logic [N_CH-1:0]     grant_q, win;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                beat, done;

`ifdef RAM_ARB_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;
    ram_arb_pick #(.N_CH(N_CH), .PW(PW)) u_pick (.Req(Req), .Ptr(ptr_q), .Winner(win));
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < N_CH; i++)
            if (win[i]) ptr_d = PW'((i + 1) % N_CH);
    end
`else
    ram_arb_pick #(.N_CH(N_CH), .PW(PW)) u_pick (.Req(Req), .Winner(win));
`endif

    always_comb begin
        AddressToRAM = '0;
        for (int i = 0; i < N_CH; i++)
            AddressToRAM = AddressToRAM | (AddrIn[i*AW +: AW] & {AW{grant_q[i]}});
    end

    assign Grant     = grant_q;
    assign BeatCount = beat_q;
    assign AddrValid = |(grant_q & Req);
    assign Take      = grant_q & Req & {N_CH{RamReady}};
    assign beat      = |Take;
    assign beat_d    = beat_q + BEAT_W'(1);
    // a dropped request releases without a beat; Last and MAX_BURST together release once
    assign done      = !AddrValid || (beat && (|(grant_q & Last) || beat_q == LAST_BEAT));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            beat_q  <= '0;
`ifdef RAM_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (|Req) begin
                    state_q <= ST_BUSY;
                    grant_q <= win;
                    beat_q  <= '0;
`ifdef RAM_ARB_RR_EN
                    ptr_q   <= ptr_d;
`endif
                end
                ST_BUSY: begin
                    if (beat) beat_q <= beat_d;
                    if (done) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_addr_arbiter.sv
// tb_ram_addr_arbiter: directed checks of reset, priority, burst limit, back-pressure, abort and arbitration order.
module tb_ram_addr_arbiter;
    logic        Clk, Rst, RamReady, AddrValid;
    logic [3:0]  Req, Last, Grant, Take;
    logic [63:0] AddrIn;
    logic [15:0] AddressToRAM;
    logic [7:0]  BeatCount;
    int total = 0;
    int bad = 0;

    ram_addr_arbiter #(.N_CH(4), .AW(16), .MAX_BURST(4)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Last(Last), .AddrIn(AddrIn), .RamReady(RamReady),
        .Grant(Grant), .Take(Take), .AddressToRAM(AddressToRAM), .AddrValid(AddrValid), .BeatCount(BeatCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Rst = 1'b1; Req = 4'b1111; Last = '0; RamReady = 1'b1;
        AddrIn = {16'hD004, 16'hC003, 16'hB002, 16'h1234};
        for (int c = 0; c < 2; c++) begin
            tick;
            total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", Grant); end
            total++; if (AddressToRAM !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h want=0000", AddressToRAM); end
            total++; if (AddrValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", AddrValid); end
            total++; if (BeatCount !== 8'd0) begin bad++; $display("FAIL rst_beats got=%0d want=0", BeatCount); end
        end
        Rst = 1'b0; Req = '0;
        tick;
    endtask

    task automatic test_fixed_prio;
        Req = 4'b0110; Last = '0; RamReady = 1'b1;
        tick;
        for (int b = 0; b < 3; b++) begin
            Last = (b == 2) ? 4'b0010 : 4'b0000;
            #1;
            total++; if (Grant !== 4'b0010) begin bad++; $display("FAIL prio_grant got=%b want=0010", Grant); end
            total++; if (Take !== 4'b0010) begin bad++; $display("FAIL prio_take got=%b want=0010", Take); end
            total++; if (AddressToRAM !== 16'hB002) begin bad++; $display("FAIL prio_addr got=%h want=b002", AddressToRAM); end
            total++; if (BeatCount !== 8'(b)) begin bad++; $display("FAIL prio_beats got=%0d want=%0d", BeatCount, b); end
            tick;
        end
        Last = '0; Req = 4'b0100;
        #1;
        total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL prio_bubble got=%b want=0000", Grant); end
        total++; if (BeatCount !== 8'd3) begin bad++; $display("FAIL prio_final_beats got=%0d want=3", BeatCount); end
        tick;
        total++; if (Grant !== 4'b0100) begin bad++; $display("FAIL prio_next got=%b want=0100", Grant); end
        total++; if (AddressToRAM !== 16'hC003) begin bad++; $display("FAIL prio_next_addr got=%h want=c003", AddressToRAM); end
        Req = '0;
        tick;
        tick;
    endtask

    task automatic test_max_burst;
        Req = 4'b0001; Last = '0; RamReady = 1'b1;
        tick;
        for (int b = 0; b < 4; b++) begin
            total++; if (Take !== 4'b0001) begin bad++; $display("FAIL burst_take got=%b want=0001", Take); end
            total++; if (BeatCount !== 8'(b)) begin bad++; $display("FAIL burst_beats got=%0d want=%0d", BeatCount, b); end
            tick;
        end
        total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL burst_release got=%b want=0000", Grant); end
        total++; if (BeatCount !== 8'd4) begin bad++; $display("FAIL burst_count got=%0d want=4", BeatCount); end
        tick;
        total++; if (Grant !== 4'b0001) begin bad++; $display("FAIL burst_regrant got=%b want=0001", Grant); end
        total++; if (BeatCount !== 8'd0) begin bad++; $display("FAIL burst_clear got=%0d want=0", BeatCount); end
        Req = '0;
        tick;
        tick;
    endtask

    task automatic test_backpressure;
        int pat[4] = '{1, 0, 0, 1};
        int cnt = 0;
        Req = 4'b0001; Last = '0; RamReady = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            RamReady = pat[i][0];
            #1;
            total++; if (AddressToRAM !== 16'h1234) begin bad++; $display("FAIL bp_addr got=%h want=1234", AddressToRAM); end
            total++; if (Take !== (pat[i] != 0 ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL bp_take cyc=%0d got=%b want_ready=%0d", i, Take, pat[i]); end
            total++; if (BeatCount !== 8'(cnt)) begin bad++; $display("FAIL bp_beats got=%0d want=%0d", BeatCount, cnt); end
            if (pat[i] != 0) cnt++;
            tick;
        end
        total++; if (Grant !== 4'b0001) begin bad++; $display("FAIL bp_hold got=%b want=0001", Grant); end
        total++; if (BeatCount !== 8'd2) begin bad++; $display("FAIL bp_total got=%0d want=2", BeatCount); end
        Req = '0; RamReady = 1'b1;
        tick;
        tick;
    endtask

    task automatic test_abort;
        Req = 4'b0010; Last = '0; RamReady = 1'b1;
        tick;
        total++; if (Take !== 4'b0010) begin bad++; $display("FAIL abort_first_take got=%b want=0010", Take); end
        tick;
        Req = '0;
        #1;
        total++; if (AddrValid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", AddrValid); end
        total++; if (Take !== 4'b0000) begin bad++; $display("FAIL abort_take got=%b want=0000", Take); end
        total++; if (Grant !== 4'b0010) begin bad++; $display("FAIL abort_hold got=%b want=0010", Grant); end
        tick;
        total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL abort_release got=%b want=0000", Grant); end
        total++; if (BeatCount !== 8'd1) begin bad++; $display("FAIL abort_beats got=%0d want=1", BeatCount); end
    endtask

    task automatic test_arbitration_order;
        logic [3:0] exp;
        Rst = 1'b1; Req = '0;
        tick;
        Rst = 1'b0; Req = 4'b1111; Last = 4'b1111; RamReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
`ifdef RAM_ARB_RR_EN
            exp = 4'b0001 << (k % 4);
`else
            exp = 4'b0001;
`endif
            tick;
            total++; if (Grant !== exp) begin bad++; $display("FAIL order_grant k=%0d got=%b want=%b", k, Grant, exp); end
            total++; if (Take !== exp) begin bad++; $display("FAIL order_take k=%0d got=%b want=%b", k, Take, exp); end
            tick;
            total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL order_bubble k=%0d got=%b want=0000", k, Grant); end
        end
        Req = '0; Last = '0;
        tick;
    endtask

    initial begin
        test_reset;
        test_fixed_prio;
        test_max_burst;
        test_backpressure;
        test_abort;
        test_arbitration_order;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
